// File: rtl/rv_mem_arb.sv
// Single-bus memory arbiter: sequences fetch and load/store transactions one at a time,
// with data-priority arbitration bounded by a streak limit and a bus-ack watchdog.
module rv_mem_arb #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int DATA_STREAK_MAX = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_pc_change,
  input  logic                i_inst_req,
  input  logic [ADDR_W-1:0]   i_inst_addr,
  output logic                o_inst_gnt,
  output logic                o_inst_rvalid,
  output logic [DATA_W-1:0]   o_inst_rdata,
  output logic                o_inst_err,
  input  logic                i_data_req,
  input  logic                i_data_we,
  input  logic [ADDR_W-1:0]   i_data_addr,
  input  logic [DATA_W/8-1:0] i_data_sel,
  input  logic [DATA_W-1:0]   i_data_wdata,
  output logic                o_data_gnt,
  output logic                o_data_rvalid,
  output logic [DATA_W-1:0]   o_data_rdata,
  output logic                o_data_err,
  output logic                o_need_pause,
  output logic                o_bus_req,
  output logic                o_bus_we,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [DATA_W/8-1:0] o_bus_sel,
  output logic [DATA_W-1:0]   o_bus_wdata,
  input  logic                i_bus_ack,
  input  logic [DATA_W-1:0]   i_bus_rdata
);
  localparam int SEL_W    = DATA_W / 8;
  localparam int STREAK_W = 4;
  localparam int TO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY} state_t;

  state_t              state_q, state_d;
  logic [STREAK_W-1:0] streak_q;
  logic [TO_W-1:0]     tcnt_q;
  logic                discard_q;
  logic                inst_elig, gnt_inst, gnt_data, timeout;

  always_comb begin
    inst_elig = i_inst_req && !i_pc_change;
    gnt_inst  = 1'b0;
    gnt_data  = 1'b0;
    timeout   = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (!i_reset) begin
          // Data wins contention until it has taken DATA_STREAK_MAX grants in a row.
          if (i_data_req && !(inst_elig && streak_q >= STREAK_W'(DATA_STREAK_MAX)))
            gnt_data = 1'b1;
          else if (inst_elig)
            gnt_inst = 1'b1;
        end
        if (gnt_data)      state_d = DATA_BUSY;
        else if (gnt_inst) state_d = INST_BUSY;
      end
      INST_BUSY, DATA_BUSY: begin
        timeout = (TIMEOUT_CYCLES > 0) && !i_bus_ack && (tcnt_q == TO_W'(TIMEOUT_CYCLES));
        if (i_bus_ack || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_inst_gnt   = gnt_inst;
  assign o_data_gnt   = gnt_data;
  assign o_need_pause = !i_reset && ((i_data_req && !gnt_data) || (state_q == DATA_BUSY));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      streak_q      <= '0;
      tcnt_q        <= '0;
      discard_q     <= 1'b0;
      o_bus_req     <= 1'b0;
      o_bus_we      <= 1'b0;
      o_bus_addr    <= '0;
      o_bus_sel     <= '0;
      o_bus_wdata   <= '0;
      o_inst_rvalid <= 1'b0;
      o_inst_rdata  <= '0;
      o_inst_err    <= 1'b0;
      o_data_rvalid <= 1'b0;
      o_data_rdata  <= '0;
      o_data_err    <= 1'b0;
    end else begin
      state_q       <= state_d;
      o_inst_rvalid <= 1'b0;
      o_inst_err    <= 1'b0;
      o_data_rvalid <= 1'b0;
      o_data_err    <= 1'b0;

      if (gnt_data) begin
        o_bus_req   <= 1'b1;
        o_bus_we    <= i_data_we;
        o_bus_addr  <= i_data_addr;
        o_bus_sel   <= i_data_sel;
        o_bus_wdata <= i_data_wdata;
        tcnt_q      <= '0;
        discard_q   <= 1'b0;
        if (inst_elig && streak_q != {STREAK_W{1'b1}})
          streak_q <= streak_q + STREAK_W'(1);
      end else if (gnt_inst) begin
        o_bus_req   <= 1'b1;
        o_bus_we    <= 1'b0;
        o_bus_addr  <= i_inst_addr;
        o_bus_sel   <= {SEL_W{1'b1}};
        o_bus_wdata <= '0;
        tcnt_q      <= '0;
        discard_q   <= 1'b0;
        streak_q    <= '0;
      end

      if (state_q != IDLE) begin
        if (i_bus_ack || timeout) begin
          o_bus_req <= 1'b0;
          discard_q <= 1'b0;
          if (state_q == DATA_BUSY) begin
            o_data_rvalid <= 1'b1;
            o_data_rdata  <= timeout ? '0 : i_bus_rdata;
            o_data_err    <= timeout;
          end else if (!discard_q && !i_pc_change) begin
            o_inst_rvalid <= 1'b1;
            o_inst_rdata  <= timeout ? '0 : i_bus_rdata;
            o_inst_err    <= timeout;
          end
        end else begin
          tcnt_q <= tcnt_q + TO_W'(1);
          // A redirect while the fetch is on the bus makes its response stale.
          if (state_q == INST_BUSY && i_pc_change) discard_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv_mem_arb.sv
// Randomized bench for rv_mem_arb: a transaction-level model predicts grants, bus
// activity and responses; responses are scoreboarded and checked by a monitor.
module tb_rv_mem_arb;
  localparam int AW = 32, DW = 32, SW = 4, SMAX = 4, TO = 8;

  logic          i_clk = 1'b0, i_reset = 1'b1, i_pc_change = 1'b0;
  logic          i_inst_req = 1'b0;
  logic [AW-1:0] i_inst_addr = '0;
  logic          i_data_req = 1'b0, i_data_we = 1'b0;
  logic [AW-1:0] i_data_addr = '0;
  logic [SW-1:0] i_data_sel = '0;
  logic [DW-1:0] i_data_wdata = '0;
  logic          i_bus_ack = 1'b0;
  logic [DW-1:0] i_bus_rdata = '0;
  logic          o_inst_gnt, o_inst_rvalid, o_inst_err;
  logic [DW-1:0] o_inst_rdata;
  logic          o_data_gnt, o_data_rvalid, o_data_err, o_need_pause;
  logic [DW-1:0] o_data_rdata;
  logic          o_bus_req, o_bus_we;
  logic [AW-1:0] o_bus_addr;
  logic [SW-1:0] o_bus_sel;
  logic [DW-1:0] o_bus_wdata;

  rv_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .DATA_STREAK_MAX(SMAX), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pc_change(i_pc_change),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr), .o_inst_gnt(o_inst_gnt),
    .o_inst_rvalid(o_inst_rvalid), .o_inst_rdata(o_inst_rdata), .o_inst_err(o_inst_err),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
    .i_data_sel(i_data_sel), .i_data_wdata(i_data_wdata), .o_data_gnt(o_data_gnt),
    .o_data_rvalid(o_data_rvalid), .o_data_rdata(o_data_rdata), .o_data_err(o_data_err),
    .o_need_pause(o_need_pause), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_sel(o_bus_sel), .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit            inst;
    bit            err;
    logic [DW-1:0] rdata;
    int            cyc;
  } resp_t;
  resp_t exp_q[$];
  resp_t mon_e;

  // Response monitor: every rvalid pulse must match the oldest predicted response.
  always @(negedge i_clk) begin
    if (!i_reset && (o_inst_rvalid || o_data_rvalid)) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL resp_unexpected: got inst=%0b data=%0b expected none (cycle %0d)",
                 o_inst_rvalid, o_data_rvalid, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_owner", {o_inst_rvalid, o_data_rvalid}, mon_e.inst ? 2'b10 : 2'b01);
        chk("resp_cycle", cyc, mon_e.cyc);
        chk("resp_err", mon_e.inst ? o_inst_err : o_data_err, mon_e.err);
        chk("resp_rdata", mon_e.inst ? o_inst_rdata : o_data_rdata, mon_e.rdata);
      end
    end
  end

  // Transaction model: one record per granted transaction, timed by cycle numbers.
  bit            t_act = 0, t_inst = 0, t_disc = 0;
  int            t_g = 0, t_ack = -1, t_end = 0;
  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [SW-1:0] t_sel;
  logic [DW-1:0] t_wdata, t_rdata;
  int            streak = 0;
  int            p_inst = 0, p_data = 0, p_pc = 0, d_min = 2, d_max = 2;
  bit            drop_i = 0, drop_d = 0;
  bit            gq[$];

  task automatic step();
    bit idle, in_bus, ie, ed, ei;
    int d;
    @(negedge i_clk);
    if (drop_i) begin i_inst_req = 1'b0; drop_i = 0; end
    if (drop_d) begin i_data_req = 1'b0; drop_d = 0; end
    if (!i_inst_req && $urandom_range(99) < p_inst) begin
      i_inst_req  = 1'b1;
      i_inst_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!i_data_req && $urandom_range(99) < p_data) begin
      i_data_req   = 1'b1;
      i_data_we    = 1'($urandom_range(1));
      i_data_addr  = $urandom;
      i_data_sel   = 4'($urandom_range(15, 1));
      i_data_wdata = $urandom;
    end
    i_pc_change = ($urandom_range(99) < p_pc);
    idle   = !t_act || cyc > t_end;
    in_bus = t_act && cyc > t_g && cyc <= t_end;
    if (in_bus && cyc == t_ack) begin
      i_bus_ack = 1'b1; i_bus_rdata = t_rdata;
    end else begin
      i_bus_ack = 1'b0; i_bus_rdata = $urandom;
    end
    #1;
    ie = i_inst_req && !i_pc_change;
    ed = idle && i_data_req && !(ie && streak >= SMAX);
    ei = idle && ie && !ed;
    chk("data_gnt", o_data_gnt, ed);
    chk("inst_gnt", o_inst_gnt, ei);
    chk("bus_req", o_bus_req, in_bus);
    chk("need_pause", o_need_pause, (i_data_req && !ed) || (in_bus && !t_inst));
    if (in_bus) begin
      chk("bus_addr", o_bus_addr, t_addr);
      chk("bus_we", o_bus_we, t_we);
      chk("bus_sel", o_bus_sel, t_sel);
      if (!t_inst) chk("bus_wdata", o_bus_wdata, t_wdata);
      if (t_inst && i_pc_change) t_disc = 1;
      if (cyc == t_end) begin
        if (!(t_inst && t_disc))
          exp_q.push_back('{inst: t_inst, err: (t_ack < 0), rdata: (t_ack < 0) ? '0 : t_rdata,
                            cyc: cyc + 1});
        t_act = 0;
      end
    end
    if (o_data_gnt) gq.push_back(1'b1);
    else if (o_inst_gnt) gq.push_back(1'b0);
    drop_d = o_data_gnt;
    drop_i = o_inst_gnt;
    if (ed || ei) begin
      t_act = 1; t_inst = ei; t_disc = 0; t_g = cyc;
      t_we    = ed ? i_data_we : 1'b0;
      t_addr  = ed ? i_data_addr : i_inst_addr;
      t_sel   = ed ? i_data_sel : 4'hF;
      t_wdata = i_data_wdata;
      t_rdata = $urandom;
      d = $urandom_range(d_max, d_min);
      if (d <= TO + 1) begin t_ack = cyc + d; t_end = t_ack; end
      else begin t_ack = -1; t_end = cyc + TO + 1; end
      if (ed && ie && streak < 15) streak++;
      if (ei) streak = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bus_req"}, o_bus_req, 0);
    chk({tag, "_bus_we"}, o_bus_we, 0);
    chk({tag, "_bus_addr"}, o_bus_addr, 0);
    chk({tag, "_bus_sel"}, o_bus_sel, 0);
    chk({tag, "_bus_wdata"}, o_bus_wdata, 0);
    chk({tag, "_rvalids"}, {o_inst_rvalid, o_data_rvalid}, 0);
    chk({tag, "_errs"}, {o_inst_err, o_data_err}, 0);
    chk({tag, "_inst_rdata"}, o_inst_rdata, 0);
    chk({tag, "_data_rdata"}, o_data_rdata, 0);
    chk({tag, "_gnts"}, {o_inst_gnt, o_data_gnt}, 0);
    chk({tag, "_need_pause"}, o_need_pause, 0);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  bit exp_ord[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_reset = 1'b0;

    // Both requesters saturated: four data grants, then one forced fetch grant.
    p_inst = 100; p_data = 100; p_pc = 0; d_min = 2; d_max = 2;
    for (int n = 0; n < 200 && gq.size() < 10; n++) step();
    chk("order_len", gq.size() >= 10, 1);
    for (int k = 0; k < 10 && k < gq.size(); k++) chk($sformatf("order_%0d", k), gq[k], exp_ord[k]);
    p_inst = 0; p_data = 0; run(30);

    p_inst = 40; p_data = 40; p_pc = 10; d_min = 2; d_max = TO + 3; run(1500);
    p_pc = 20; d_min = TO + 2; d_max = TO + 3; run(300);
    p_inst = 80; p_data = 10; p_pc = 30; d_min = 2; d_max = 5; run(400);
    p_inst = 0; p_data = 0; p_pc = 0; run(40);
    chk("drain_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a stalled data transaction.
    p_data = 100; d_min = TO + 3; d_max = TO + 3;
    for (int n = 0; n < 20 && !drop_d; n++) step();
    p_data = 0;
    run(3);
    chk("pre_reset_busy", o_bus_req, 1);
    @(posedge i_clk); #2;
    i_reset = 1'b1; i_inst_req = 1'b0; i_data_req = 1'b0; i_bus_ack = 1'b0;
    #1;
    chk_zero("midreset");
    t_act = 0; streak = 0; drop_i = 0; drop_d = 0; exp_q.delete();
    @(negedge i_clk); i_reset = 1'b0;
    run(20);

    // Service resumes normally after reset.
    p_data = 100; d_min = 3; d_max = 3;
    for (int n = 0; n < 20 && !drop_d; n++) step();
    p_data = 0; run(10);
    chk("final_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
